// File: rtl/key_event_capture.sv
// key_event_capture: synchronises the active-low priority-encoder outputs,
// debounces press and release, and emits press / auto-repeat key events
// through a single-entry valid/ready output register.
module key_event_capture #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_PERIOD   = 2000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qc,
  input  logic       qb,
  input  logic       qa,
  input  logic       gs,
  output logic [2:0] key_code,
  output logic       key_repeat,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun,
  input  logic       clr_overrun
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
  typedef enum logic {PH_DELAY, PH_PERIOD} phase_t;

  typedef struct packed {
    logic [2:0] code;
    logic       rep;
  } key_evt_t;

  // Compare against "limit - 1" so a counter starting at 0 fires on the limit-th edge.
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               REP_EN     = (REPEAT_DELAY != 0);

  logic [3:0]       sync1, sync2;
  logic             s_gs;
  logic [2:0]       s_code;

  state_t           state, state_n;
  logic [2:0]       cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
  phase_t           rep_phase, rep_phase_n;
  logic [CNT_W-1:0] rep_last;

  logic             ev_vld;
  key_evt_t         ev;
  logic             take, drop;

  // Two-flop synchroniser; idles at "no key" (all ones, active-low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= {gs, qc, qb, qa};
      sync2 <= sync1;
    end
  end

  assign s_gs     = sync2[3];
  assign s_code   = ~sync2[2:0];
  assign rep_last = (rep_phase == PH_DELAY) ? DELAY_LAST : PER_LAST;

  // FSM and counter registers; key_held is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      rep_cnt   <= '0;
      rep_phase <= PH_DELAY;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      rep_cnt   <= rep_cnt_n;
      rep_phase <= rep_phase_n;
      key_held  <= (state_n == HELD) || (state_n == REL_DB);
    end
  end

  // Debounce / repeat next-state logic; raises ev_vld for one cycle per event.
  always_comb begin
    state_n     = state;
    cand_n      = cand;
    cnt_n       = cnt;
    rep_cnt_n   = rep_cnt;
    rep_phase_n = rep_phase;
    ev_vld      = 1'b0;
    ev          = '{code: cand, rep: 1'b0};
    case (state)
      IDLE: begin
        if (!s_gs) begin
          state_n = PRESS_DB;
          cand_n  = s_code;
          cnt_n   = '0;
        end
      end
      PRESS_DB: begin
        if (s_gs) begin
          state_n = IDLE;
        end else if (s_code != cand) begin
          cand_n = s_code;
          cnt_n  = '0;
        end else if (cnt == DB_LAST) begin
          state_n     = HELD;
          ev_vld      = 1'b1;
          rep_cnt_n   = '0;
          rep_phase_n = PH_DELAY;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        // Repeat counters freeze while in REL_DB so a bounce does not reset them.
        if (s_gs || (s_code != cand)) begin
          state_n = REL_DB;
          cnt_n   = '0;
        end else if (REP_EN) begin
          if (rep_cnt == rep_last) begin
            ev_vld      = 1'b1;
            ev.rep      = 1'b1;
            rep_cnt_n   = '0;
            rep_phase_n = PH_PERIOD;
          end else begin
            rep_cnt_n = rep_cnt + 1'b1;
          end
        end
      end
      REL_DB: begin
        // Any other key pressed counts as a release of the held one.
        if (!s_gs && (s_code == cand)) begin
          state_n = HELD;
        end else if (cnt == DB_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A slot freed by a same-cycle handshake can take the new event.
  assign take = ev_vld && (!key_valid || key_ready);
  assign drop = ev_vld && key_valid && !key_ready;

  // Single-entry output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code   <= '0;
      key_repeat <= 1'b0;
      key_valid  <= 1'b0;
    end else if (take) begin
      key_code   <= ev.code;
      key_repeat <= ev.rep;
      key_valid  <= 1'b1;
    end else if (key_valid && key_ready) begin
      key_valid  <= 1'b0;
    end
  end

  // Sticky overrun; a drop in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_key_event_capture.sv
// Bench for key_event_capture: run-length reference model + event scoreboard,
// directed scenarios followed by randomized key activity.
module tb_key_event_capture;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n, qc, qb, qa, gs, key_ready, clr_overrun;
  logic [2:0] key_code;
  logic       key_repeat, key_valid, key_held, overrun;

  int chk  = 0;
  int errs = 0;

  key_event_capture #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .qc(qc), .qb(qb), .qa(qa), .gs(gs),
    .key_code(key_code), .key_repeat(key_repeat), .key_valid(key_valid),
    .key_ready(key_ready), .key_held(key_held), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] code;
    logic       rep;
  } evt_t;

  evt_t exp_q[$];

  // Reference model: press accepted after DC+1 identical pressed samples,
  // release after DC+1 non-matching samples, repeat timer counts matching
  // samples that follow a matching sample.
  logic [3:0] d1, d2;
  int         run, miss, rep_t, rep_lim;
  logic [2:0] rcode, mcand;
  bit         mheld, prev_ok, mv, mov;

  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    d1 = 4'b1111; d2 = 4'b1111;
    run = 0; miss = 0; rep_t = 0; rep_lim = RD;
    rcode = '0; mcand = '0;
    mheld = 0; prev_ok = 0; mv = 0; mov = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [3:0] s;
    bit         pressed, match, ev, drop;
    evt_t       e;
    s = d2; d2 = d1; d1 = {gs, qc, qb, qa};
    pressed = !s[3];
    ev = 0;
    e = '{code: 3'd0, rep: 1'b0};
    if (!mheld) begin
      if (pressed) begin
        if (run > 0 && ~s[2:0] == rcode) run++;
        else begin run = 1; rcode = ~s[2:0]; end
        if (run == DC + 1) begin
          ev = 1; e = '{code: rcode, rep: 1'b0};
          mheld = 1; mcand = rcode; miss = 0;
          rep_t = 0; rep_lim = RD; prev_ok = 1;
        end
      end else run = 0;
    end else begin
      match = pressed && (~s[2:0] == mcand);
      if (!match) begin
        miss++; prev_ok = 0;
        if (miss == DC + 1) begin mheld = 0; run = 0; end
      end else begin
        miss = 0;
        if (prev_ok && RD != 0) begin
          rep_t++;
          if (rep_t == rep_lim) begin
            ev = 1; e = '{code: mcand, rep: 1'b1};
            rep_t = 0; rep_lim = RP;
          end
        end
        prev_ok = 1;
      end
    end
    drop = ev && mv && !key_ready;
    if (ev && (!mv || key_ready)) begin mv = 1; exp_q.push_back(e); end
    else if (mv && key_ready) mv = 0;
    if (drop) mov = 1;
    else if (clr_overrun) mov = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: per-cycle status compare and scoreboard pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      check("valid", key_valid, mv);
      check("held", key_held, mheld);
      check("overrun", overrun, mov);
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          chk++; errs++;
          $display("FAIL event: got code=%0d rep=%0d, want none", key_code, key_repeat);
        end else begin
          check("event_code", key_code, exp_q[0].code);
          check("event_repeat", key_repeat, exp_q[0].rep);
          if (key_ready && rst_n) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic set_key(input logic g, input logic [2:0] c);
    gs = g; {qc, qb, qa} = ~c;
  endtask

  task automatic hold(input logic g, input logic [2:0] c, input int n);
    set_key(g, c);
    repeat (n) tick();
  endtask

  // Edges (1-based from the call) until key_valid is seen; -1 if never.
  task automatic wait_valid(input int maxn, output int got);
    got = -1;
    for (int k = 1; k <= maxn; k++) begin
      @(posedge clk); #4;
      if (key_valid) begin got = k; break; end
    end
  endtask

  initial begin
    int got, nrep, nval;
    rst_n = 1'b0; key_ready = 1'b1; clr_overrun = 1'b0;
    set_key(1'b1, 3'd0);
    repeat (3) tick();
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_repeat", key_repeat, 0);
    check("rst_held", key_held, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    hold(1'b1, 3'd0, 5);

    // Clean press of key 5
    set_key(1'b0, 3'd5);
    wait_valid(30, got);
    check("press_latency", got, DC + 3);
    check("press_code", key_code, 5);
    check("press_repeat", key_repeat, 0);
    hold(1'b0, 3'd5, 10);
    check("press_held", key_held, 1);
    hold(1'b1, 3'd0, 12);
    check("release_held", key_held, 0);

    // Bouncy press settling on key 3
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 3'd3, 2);
      hold(1'b1, 3'd0, 2);
    end
    check("bounce_no_event", key_valid, 0);
    set_key(1'b0, 3'd3);
    wait_valid(30, got);
    check("bounce_latency", got, DC + 3);
    check("bounce_code", key_code, 3);
    hold(1'b0, 3'd3, 5);
    hold(1'b1, 3'd0, 12);

    // Auto-repeat on key 7: repeats at T+20, +28, ..., +60
    set_key(1'b0, 3'd7);
    wait_valid(30, got);
    check("rep_first_latency", got, DC + 3);
    nrep = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #4;
      if (key_valid && key_repeat) nrep++;
    end
    check("rep_count", nrep, 6);
    set_key(1'b1, 3'd0);
    nval = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #4;
      if (key_valid) nval++;
    end
    check("rep_stop_after_release", nval, 0);
    tick();

    // Release bounce on key 2
    set_key(1'b0, 3'd2);
    wait_valid(30, got);
    check("rb_latency", got, DC + 3);
    hold(1'b0, 3'd2, 5);
    hold(1'b1, 3'd0, 2);
    set_key(1'b0, 3'd2);
    nval = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("rb_held", key_held, 1);
      if (key_valid && !key_repeat) nval++;
    end
    check("rb_no_new_press", nval, 0);
    hold(1'b1, 3'd0, 12);

    // Backpressure on key 1
    key_ready = 1'b0;
    hold(1'b0, 3'd1, 30);
    check("bp_valid", key_valid, 1);
    check("bp_code", key_code, 1);
    check("bp_repeat", key_repeat, 0);
    check("bp_overrun", overrun, 1);
    key_ready = 1'b1; clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("bp_overrun_cleared", overrun, 0);
    check("bp_valid_drained", key_valid, 0);
    wait_valid(10, got);
    check("bp_next_repeat_edge", got, 4);
    check("bp_next_code", key_code, 1);
    check("bp_next_repeat", key_repeat, 1);
    hold(1'b1, 3'd0, 12);

    // Async reset while a new press is debouncing
    key_ready = 1'b0;
    hold(1'b0, 3'd6, 30);
    hold(1'b1, 3'd0, 10);
    hold(1'b0, 3'd4, 3);
    check("pre_rst_valid", key_valid, 1);
    check("pre_rst_overrun", overrun, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_held", key_held, 0);
    check("mid_rst_overrun", overrun, 0);
    key_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    wait_valid(30, got);
    check("post_rst_latency", got, DC + 3);
    check("post_rst_code", key_code, 4);
    hold(1'b1, 3'd0, 12);

    // Randomized key activity with random backpressure and clears
    for (int s = 0; s < 40; s++) begin
      int n;
      set_key($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        key_ready   = ($urandom_range(0, 3) != 0);
        clr_overrun = ($urandom_range(0, 9) == 0);
        tick();
      end
    end
    key_ready = 1'b1; clr_overrun = 1'b0;
    hold(1'b1, 3'd0, 20);
    check("drain_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", chk, errs);
    $finish;
  end

endmodule

// File: doc/key_event_capture.md
# key_event_capture

Sequential key-event stage directly downstream of the 8-to-3 priority encoder in the digital clock's button path. It consumes the encoder's active-low code and group-select outputs, synchronises them to the system clock, and debounces press and release. It emits one registered key event per debounced press, plus optional auto-repeat events while the key is held. Events go through a single-entry valid/ready output register to the clock-setting controller.

## Interface
- DEBOUNCE_CYCLES, 1000: consecutive stable synchronised cycles required to accept a press or a release; legal range ≥ 1.
- REPEAT_DELAY, 5000: cycles from the accepted press to the first repeat event; 0 disables auto-repeat.
- REPEAT_PERIOD, 2000: cycles between subsequent repeat events; legal range ≥ 1.
- CNT_W, 20: counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- qc, qb, qa  in  1 each  encoder code, active-low; asynchronous to clk.
- gs  in  1  encoder group select, active-low; 0 means some key is pressed.
- key_code  out  3  accepted key index, true polarity: ~{qc,qb,qa}.
- key_repeat  out  1  0 = initial press event, 1 = auto-repeat event.
- key_valid  out  1  event available.
- key_ready  in  1  consumer accepts the event on a clk edge when key_valid=1.
- key_held  out  1  1 in states HELD and REL_DB.
- overrun  out  1  sticky flag: an event was dropped.
- clr_overrun  in  1  synchronous clear of overrun.

## Operation
- **Reset** (asynchronous, rst_n=0):
  - Both synchroniser stages for {gs,qc,qb,qa} go to 4'b1111.
  - State goes to IDLE; all counters go to 0.
  - key_code=0, key_repeat=0, key_valid=0, key_held=0, overrun=0.
- **Synchroniser:** two flops. s_gs and s_code=~{qc,qb,qa} are taken from stage 2.
- **IDLE:**
  - If s_gs=0: go to PRESS_DB with cand=s_code and cnt=0.
- **PRESS_DB:**
  - If s_gs=1: return to IDLE.
  - Else if s_code≠cand: set cand=s_code and cnt=0.
  - Else if cnt=DEBOUNCE_CYCLES-1: go to HELD, generate event {cand, repeat=0}, and set rep_cnt=0 with rep_phase=DELAY.
  - Otherwise cnt+1.
- **HELD:**
  - If s_gs=1 or s_code≠cand: go to REL_DB with cnt=0. rep_cnt and rep_phase are frozen.
  - Else if REPEAT_DELAY≠0, rep_cnt increments each cycle.
  - When rep_cnt reaches the current limit minus 1, generate event {cand, repeat=1}, set rep_cnt=0 and rep_phase=PERIOD. The limit is REPEAT_DELAY in phase DELAY and REPEAT_PERIOD in phase PERIOD.
- **REL_DB:**
  - If s_gs=0 and s_code=cand: return to HELD (release bounce). Frozen repeat counters resume.
  - Otherwise cnt+1. A different key pressed counts as release.
  - At cnt=DEBOUNCE_CYCLES-1: go to IDLE.
- **Output register:** a generated event is loaded into {key_code, key_repeat} and sets key_valid=1, when either:
  - key_valid=0, or
  - key_valid=1 and key_ready=1 in the same cycle (back-to-back, no loss).
- **Dropped event:** if key_valid=1 and key_ready=0, the new event is dropped, the held event is unchanged, and overrun sets to 1.
- **Handshake:** key_valid falls after a handshake edge with no new event. key_code and key_repeat are stable while key_valid=1 and key_ready=0.
- **overrun priority:** clr_overrun clears overrun. A drop in the same cycle wins, so overrun stays 1.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- **Press latency:** key_valid rises after edge E+DEBOUNCE_CYCLES+2, where edge E is the first edge that samples gs=0 into synchroniser stage 1.
- **First repeat:** key_valid for the first repeat rises REPEAT_DELAY edges after the initial event edge T, i.e. at T+REPEAT_DELAY.
- **Later repeats:** each subsequent repeat follows REPEAT_PERIOD edges after the previous one.
- **Minimum release time:** after gs returns to 1, IDLE is reached no earlier than DEBOUNCE_CYCLES+2 edges later. A new press cannot produce an event before IDLE is reached.
- **Reset mid-operation:** rst_n low at any time aborts the state and discards any pending event. key_valid=0 immediately.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, key_ready=1 unless stated.
- **Clean press of key 5:** {gs,qc,qb,qa}=0,0,1,0 sampled at edge 10 → key_valid=1 after edge 16 with key_code=5, key_repeat=0, for one cycle; key_held=1.
- **Bouncy press:** gs toggles 0/1 every 2 cycles for 12 cycles, then holds 0 with code 3 → exactly one event, key_code=3, DEBOUNCE_CYCLES+2 edges after the last toggle sample. No event is emitted during the bounce.
- **Auto-repeat:** hold key 7 for 60 cycles after the initial event at edge T → repeat events (key_repeat=1) at T+20, T+28, T+36, T+44, T+52, T+60 while still held. Events stop after release.
- **Release bounce:** key 2 held, gs pulses to 1 for 2 cycles (shorter than DEBOUNCE_CYCLES) → stays in HELD/REL_DB, key_held stays 1, and no new initial event is emitted.
- **Backpressure:** key_ready=0, press key 1 then let repeats occur → the first event (code 1, repeat 0) is held stable, overrun=1 after the first repeat. Raising clr_overrun and key_ready together clears overrun, and the next repeat is delivered normally.
- **Async reset mid-debounce:** rst_n=0 during PRESS_DB → all outputs 0 immediately. After release, a held key produces a fresh event with full latency DEBOUNCE_CYCLES+2.
